pwm_hbridge_gen: RTL and testbench
==================================

Name: pwm_hbridge_gen

Overview:
- Downstream consumer of the magnitude/sign stage that follows the filter.
- Takes a 32-bit unsigned magnitude and a sign bit and drives one H-bridge channel with edge-aligned PWM.
- Duty scaling and saturation are applied to the magnitude; updates are double-buffered to period boundaries.
- A dead-time interval is inserted on every direction reversal, so both bridge legs are never driven in the same cycle.

Parameters:
- CNT_W, 16, width of period counter and duty registers.
- PERIOD, 1000, PWM period in clk cycles; 2 <= PERIOD <= 2^CNT_W - 1.
- DUTY_MAX, 950, saturation ceiling for duty; DUTY_MAX <= PERIOD.
- MAG_SHIFT, 0, right shift applied to magnitude before saturation (0..31).
- DEADTIME, 20, clk cycles both legs held low on a direction reversal; >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mag_in  in  32  unsigned magnitude from the sign-split stage
- sign_in  in  1  1 = negative/reverse
- load  in  1  single-cycle strobe: capture mag_in/sign_in
- pwm_a  out  1  forward leg drive
- pwm_b  out  1  reverse leg drive
- dir_out  out  1  currently applied direction
- duty_q  out  CNT_W  currently applied duty
- period_start  out  1  one-cycle pulse, registered, coincident with the first PWM cycle of each period
- dead_active  out  1  high while in DEAD state

Behaviour:
- Reset: one clk edge with rst=1 clears cnt, pending regs, pend flag, state to RUN, and all outputs to 0. This takes effect from any state, mid-period or mid-dead-time.
- Counter: cnt counts 0..PERIOD-1 and wraps to 0. Boundary = cycle where cnt==PERIOD-1.
- Capture: on load, pend_duty <= min(mag_in >> MAG_SHIFT, DUTY_MAX), pend_sign <= sign_in, pend <= 1.
  - Comparison is full 32-bit unsigned, so 0x8000_0000 saturates.
  - A later load overwrites an earlier one; last write wins.
- Load coincident with boundary: the boundary uses pend regs as held before that edge. The new value is applied at the following boundary.
- State RUN, at boundary with pend=1:
  - If pend_sign==dir_out or pend_duty==0: duty_q <= pend_duty, pend <= 0.
  - Otherwise: go to DEAD, duty_q <= 0, dead counter <= 0.
  - A zero duty never triggers dead time, and dir_out is unchanged in that case.
- State DEAD:
  - pwm_a = pwm_b = 0; counter keeps running; dead counter increments each cycle.
  - After DEADTIME cycles: dir_out <= pend_sign, state RUN, pend stays 1.
  - Duty is applied at the next boundary through the RUN rule, which now sees equal signs.
  - Loads during DEAD are accepted. Whatever pend_sign holds when DEAD ends is the direction applied.
- PWM: on = (state==RUN) && (cnt < duty_q), evaluated on the cycle's cnt.
  - pwm_a <= on & ~dir_out; pwm_b <= on & dir_out; one-cycle registered latency.
  - pwm_a & pwm_b is never 1.
- period_start <= (cnt==0), so it is aligned with the registered pwm outputs.
- Latency: a load in period k appears on pwm from the first cycle of period k+1 on a same-direction change. On a reversal it appears no earlier than period k+2.
- Duty extremes: duty_q==0 gives a constant low output; duty_q==PERIOD gives a constant high output.

Decomposition:
- Shared package holds:
  - state enum {RUN, DEAD};
  - CNT_W default;
  - a saturate_shift function (32-bit in, CNT_W out), reusable by other motor channels.
- One natural sub-module, pwm_period_cnt: free-running counter producing cnt and the boundary flag.

Test Plan:
All scenarios use PERIOD=10, DUTY_MAX=8, MAG_SHIFT=0, DEADTIME=3.
- rst held 2 cycles, then released with load=0 -> pwm_a=pwm_b=0, dir_out=0, duty_q=0; period_start pulses every 10 cycles.
- load mag_in=4 sign_in=0 mid-period -> next period: pwm_a high exactly 4 of 10 cycles, pwm_b=0, duty_q=4.
- Saturation: load mag_in=100 -> duty_q=8, pwm_a high 8 of 10. Then load mag_in=0x8000_0000 sign_in=1 -> direction reversal path with pend_duty=8.
- Reversal from dir_out=0/duty 4, load mag_in=5 sign_in=1 -> at boundary both legs low and dead_active high for 3 cycles, then dir_out=1. From the next period start, pwm_b is high 5 of 10 and pwm_a is never 1 throughout.
- load asserted exactly at cnt==9 with mag_in=6 -> current boundary keeps the old duty; duty_q=6 at the following boundary.
- rst pulsed while pwm_a high mid-period, and again during DEAD -> next cycle all outputs 0 and state RUN. Check pwm_a&pwm_b==0 on every cycle of every test.

Source files
------------

// File: rtl/pwm_hbridge_gen_pkg.sv
// Shared definitions for H-bridge PWM channels.
//   state_e        : RUN drives the bridge, DEAD holds both legs low on a reversal
//   CNT_W_DEF      : default width of period counter / duty registers
//   saturate_shift : magnitude -> duty (right shift, then clamp to a ceiling)
package pwm_hbridge_gen_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 16;

  // The clamp is a full 32-bit unsigned compare, so very large magnitudes
  // (including the top bit set) saturate instead of wrapping. The caller
  // casts the result to its duty width; the ceiling always fits there.
  function automatic logic [31:0] saturate_shift(
    input logic [31:0] mag,
    input logic [4:0]  shift,
    input logic [31:0] ceil
  );
    logic [31:0] shifted;
    shifted = mag >> shift;
    return (shifted > ceil) ? ceil : shifted;
  endfunction

endpackage

// File: rtl/pwm_hbridge_gen_cnt.sv
// Free-running PWM period counter.
//   clk, rst  : clock, synchronous active-high reset
//   cnt       : counts 0 .. PERIOD-1, then wraps to 0
//   boundary  : high on the cycle where cnt == PERIOD-1
module pwm_period_cnt #(
  parameter int CNT_W  = 16,
  parameter int PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             boundary
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    boundary = (cnt_q == LAST);
    cnt_d    = boundary ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_hbridge_gen.sv
// Edge-aligned PWM generator for one H-bridge channel.
//   clk, rst      : clock, synchronous active-high reset
//   mag_in        : unsigned magnitude, shifted and saturated into a duty
//   sign_in       : requested direction (1 = reverse)
//   load          : one-cycle strobe capturing mag_in/sign_in into pending regs
//   pwm_a, pwm_b  : forward / reverse leg drive (never both high)
//   dir_out       : direction currently applied
//   duty_q        : duty currently applied
//   period_start  : one-cycle pulse aligned with the first PWM cycle of a period
//   dead_active   : high while both legs are held off for a reversal
module pwm_hbridge_gen
  import pwm_hbridge_gen_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int PERIOD    = 1000,
  parameter int DUTY_MAX  = 950,
  parameter int MAG_SHIFT = 0,
  parameter int DEADTIME  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      mag_in,
  input  logic             sign_in,
  input  logic             load,
  output logic             pwm_a,
  output logic             pwm_b,
  output logic             dir_out,
  output logic [CNT_W-1:0] duty_q,
  output logic             period_start,
  output logic             dead_active
);

  localparam logic [31:0]        DUTY_CEIL = 32'(DUTY_MAX);
  localparam logic [4:0]         SHIFT     = 5'(MAG_SHIFT);
  localparam int                 DEAD_W    = $clog2(DEADTIME + 1);
  localparam logic [DEAD_W-1:0]  DEAD_LAST = DEAD_W'(DEADTIME - 1);

  logic [CNT_W-1:0] cnt;
  logic             boundary;

  pwm_period_cnt #(
    .CNT_W  (CNT_W),
    .PERIOD (PERIOD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .boundary (boundary)
  );

  state_e            state_q,     state_d;
  logic              dir_q,       dir_d;
  logic [CNT_W-1:0]  duty_d;
  logic              pend_q,      pend_d;
  logic [CNT_W-1:0]  pend_duty_q, pend_duty_d;
  logic              pend_sign_q, pend_sign_d;
  logic [DEAD_W-1:0] dead_cnt_q,  dead_cnt_d;

  logic on_p0;
  logic pwm_a_p1, pwm_b_p1, period_start_p1;

  // Stage 0: control state update and PWM compare on the current cnt
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    duty_d      = duty_q;
    pend_d      = pend_q;
    pend_duty_d = pend_duty_q;
    pend_sign_d = pend_sign_q;
    dead_cnt_d  = dead_cnt_q;

    case (state_q)
      ST_RUN: begin
        if (boundary && pend_q) begin
          // A zero duty drives nothing, so it is applied without a reversal.
          if ((pend_sign_q == dir_q) || (pend_duty_q == '0)) begin
            duty_d = pend_duty_q;
            pend_d = 1'b0;
          end else begin
            state_d    = ST_DEAD;
            duty_d     = '0;
            dead_cnt_d = '0;
          end
        end
      end
      ST_DEAD: begin
        // Duty stays pending; the next boundary in RUN applies it with
        // matching signs.
        if (dead_cnt_q == DEAD_LAST) begin
          dir_d   = pend_sign_q;
          state_d = ST_RUN;
        end else begin
          dead_cnt_d = dead_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Placed after the boundary logic: a coincident load re-arms pend for the
    // following boundary while this boundary used the previously held values.
    if (load) begin
      pend_duty_d = CNT_W'(saturate_shift(mag_in, SHIFT, DUTY_CEIL));
      pend_sign_d = sign_in;
      pend_d      = 1'b1;
    end

    on_p0 = (state_q == ST_RUN) && (cnt < duty_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      dir_q       <= 1'b0;
      duty_q      <= '0;
      pend_q      <= 1'b0;
      pend_duty_q <= '0;
      pend_sign_q <= 1'b0;
      dead_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      duty_q      <= duty_d;
      pend_q      <= pend_d;
      pend_duty_q <= pend_duty_d;
      pend_sign_q <= pend_sign_d;
      dead_cnt_q  <= dead_cnt_d;
    end
  end

  // Stage 1: registered leg drive, period marker aligned with it
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_a_p1        <= 1'b0;
      pwm_b_p1        <= 1'b0;
      period_start_p1 <= 1'b0;
    end else begin
      pwm_a_p1        <= on_p0 & ~dir_q;
      pwm_b_p1        <= on_p0 & dir_q;
      period_start_p1 <= (cnt == '0);
    end
  end

  assign pwm_a        = pwm_a_p1;
  assign pwm_b        = pwm_b_p1;
  assign period_start = period_start_p1;
  assign dir_out      = dir_q;
  assign dead_active  = (state_q == ST_DEAD);

endmodule

// File: tb/tb_pwm_hbridge_gen.sv
module tb_pwm_hbridge_gen;

  localparam int PER  = 10;
  localparam int DMAX = 8;
  localparam int SH   = 0;
  localparam int DT   = 3;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   mag_in = '0;
  logic          sign_in = 1'b0;
  logic          load = 1'b0;
  logic          pwm_a, pwm_b, dir_out, period_start, dead_active;
  logic [CW-1:0] duty_q;

  always #5 clk = ~clk;

  pwm_hbridge_gen #(
    .CNT_W     (CW),
    .PERIOD    (PER),
    .DUTY_MAX  (DMAX),
    .MAG_SHIFT (SH),
    .DEADTIME  (DT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mag_in       (mag_in),
    .sign_in      (sign_in),
    .load         (load),
    .pwm_a        (pwm_a),
    .pwm_b        (pwm_b),
    .dir_out      (dir_out),
    .duty_q       (duty_q),
    .period_start (period_start),
    .dead_active  (dead_active)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: time position inside the period, an applied setting,
  // a pending request and a remaining dead-time countdown.
  int m_cnt = 0, m_duty = 0, m_pduty = 0, m_dead_left = 0;
  bit m_dir = 0, m_pend = 0, m_psign = 0;
  bit m_pwm_a = 0, m_pwm_b = 0, m_ps = 0;

  task automatic model_step(input bit r, input bit l, input logic [31:0] mag, input bit s);
    bit on;
    bit bnd;
    logic [31:0] shifted;
    if (r) begin
      m_cnt = 0; m_duty = 0; m_pduty = 0; m_dead_left = 0;
      m_dir = 0; m_pend = 0; m_psign = 0;
      m_pwm_a = 0; m_pwm_b = 0; m_ps = 0;
      return;
    end
    on      = (m_dead_left == 0) && (m_cnt < m_duty);
    m_pwm_a = on && !m_dir;
    m_pwm_b = on && m_dir;
    m_ps    = (m_cnt == 0);
    bnd     = (m_cnt == PER - 1);
    if (m_dead_left > 0) begin
      m_dead_left--;
      if (m_dead_left == 0) m_dir = m_psign;
    end else if (bnd && m_pend) begin
      if (m_psign == m_dir || m_pduty == 0) begin
        m_duty = m_pduty;
        m_pend = 0;
      end else begin
        m_dead_left = DT;
        m_duty = 0;
      end
    end
    m_cnt = (m_cnt + 1) % PER;
    if (l) begin
      shifted = mag >> SH;
      m_pduty = (shifted > DMAX) ? DMAX : int'(shifted);
      m_psign = s;
      m_pend  = 1;
    end
  endtask

  int t_a = 0, t_b = 0, t_dead = 0, t_ps = 0;

  task automatic cyc(input bit r, input bit l, input logic [31:0] mag, input bit s);
    rst = r; load = l; mag_in = mag; sign_in = s;
    @(posedge clk);
    model_step(r, l, mag, s);
    #1;
    check_eq("pwm_a", 32'(pwm_a), 32'(m_pwm_a));
    check_eq("pwm_b", 32'(pwm_b), 32'(m_pwm_b));
    check_eq("dir_out", 32'(dir_out), 32'(m_dir));
    check_eq("duty_q", 32'(duty_q), 32'(m_duty));
    check_eq("period_start", 32'(period_start), 32'(m_ps));
    check_eq("dead_active", 32'(dead_active), 32'(m_dead_left > 0));
    check_eq("legs_exclusive", 32'(pwm_a & pwm_b), 32'd0);
    t_a    += int'(pwm_a);
    t_b    += int'(pwm_b);
    t_dead += int'(dead_active);
    t_ps   += int'(period_start);
    @(negedge clk);
    rst = 1'b0; load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'd0, 0);
  endtask

  task automatic clear_tallies();
    t_a = 0; t_b = 0; t_dead = 0; t_ps = 0;
  endtask

  // Leaves the bench at a negedge where the next edge sees cnt == c.
  task automatic wait_cnt(input int c);
    for (int i = 0; i < 2 * PER; i++) begin
      if (m_cnt == c) break;
      idle(1);
    end
  endtask

  // Finds the next period_start pulse and counts leg activity over that period.
  task automatic measure_period(output int na, output int nb);
    bit found;
    found = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      idle(1);
      if (period_start) begin
        found = 1;
        break;
      end
    end
    check_eq("period_start_seen", 32'(found), 32'd1);
    na = int'(pwm_a);
    nb = int'(pwm_b);
    for (int i = 1; i < PER; i++) begin
      idle(1);
      na += int'(pwm_a);
      nb += int'(pwm_b);
    end
  endtask

  initial begin
    int na, nb;
    bit seen;
    logic [31:0] rmag;

    // Reset and idle
    cyc(1, 0, 32'd0, 0);
    cyc(1, 0, 32'd0, 0);
    clear_tallies();
    idle(20);
    check_eq("idle_ps_count", 32'(t_ps), 32'd2);
    check_eq("idle_pwm_count", 32'(t_a + t_b), 32'd0);
    check_eq("idle_duty", 32'(duty_q), 32'd0);

    // Forward duty 4
    wait_cnt(4);
    cyc(0, 1, 32'd4, 0);
    measure_period(na, nb);
    check_eq("fwd4_a", 32'(na), 32'd4);
    check_eq("fwd4_b", 32'(nb), 32'd0);
    check_eq("fwd4_duty", 32'(duty_q), 32'd4);

    // Saturation
    wait_cnt(4);
    cyc(0, 1, 32'd100, 0);
    measure_period(na, nb);
    check_eq("sat_a", 32'(na), 32'd8);
    check_eq("sat_duty", 32'(duty_q), 32'd8);

    // Top-bit magnitude with reversal
    wait_cnt(4);
    cyc(0, 1, 32'h8000_0000, 1);
    measure_period(na, nb);
    check_eq("rev8_dead_period", 32'(na + nb), 32'd0);
    measure_period(na, nb);
    check_eq("rev8_b", 32'(nb), 32'd8);
    check_eq("rev8_a", 32'(na), 32'd0);
    check_eq("rev8_dir", 32'(dir_out), 32'd1);

    // Back to forward duty 4, then reverse to 5
    wait_cnt(4);
    cyc(0, 1, 32'd4, 0);
    idle(30);
    check_eq("back_dir", 32'(dir_out), 32'd0);
    check_eq("back_duty", 32'(duty_q), 32'd4);
    wait_cnt(4);
    clear_tallies();
    cyc(0, 1, 32'd5, 1);
    measure_period(na, nb);
    check_eq("rev5_dead_period", 32'(na + nb), 32'd0);
    measure_period(na, nb);
    check_eq("rev5_b", 32'(nb), 32'd5);
    check_eq("rev5_dead_cycles", 32'(t_dead), 32'd3);
    check_eq("rev5_a_total", 32'(t_a), 32'd0);
    check_eq("rev5_dir", 32'(dir_out), 32'd1);

    // Load exactly on the boundary cycle
    wait_cnt(PER - 1);
    cyc(0, 1, 32'd6, 1);
    check_eq("bnd_keep_old", 32'(duty_q), 32'd5);
    idle(PER);
    check_eq("bnd_new_applied", 32'(duty_q), 32'd6);

    // Reset while a leg is high
    seen = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      idle(1);
      if (pwm_b) begin
        seen = 1;
        break;
      end
    end
    check_eq("wait_leg_high", 32'(seen), 32'd1);
    cyc(1, 0, 32'd0, 0);
    check_eq("rst_mid_pwm_b", 32'(pwm_b), 32'd0);
    check_eq("rst_mid_duty", 32'(duty_q), 32'd0);
    check_eq("rst_mid_dir", 32'(dir_out), 32'd0);

    // Reset during dead time
    idle(3);
    cyc(0, 1, 32'd3, 1);
    seen = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      idle(1);
      if (dead_active) begin
        seen = 1;
        break;
      end
    end
    check_eq("wait_dead", 32'(seen), 32'd1);
    cyc(1, 0, 32'd0, 0);
    check_eq("rst_dead_dead", 32'(dead_active), 32'd0);
    check_eq("rst_dead_dir", 32'(dir_out), 32'd0);
    check_eq("rst_dead_ps", 32'(period_start), 32'd0);
    idle(PER);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: rmag = 32'($urandom_range(0, 10));
        1: rmag = $urandom;
        2: rmag = 32'h8000_0000;
        default: rmag = 32'd0;
      endcase
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0), rmag, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
